// File: rtl/finv_table_pkg.sv
// finv_table_pkg: widths, stream packing layout and loader FSM encoding shared by the finv
// seed-table writer and the finv table consumers.
`default_nettype none

package finv_table_pkg;

  localparam int FINV_ADDR_W     = 10;
  localparam int FINV_CST_W      = 58;
  localparam int FINV_GRD_W      = 35;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_ENTRY = 3;
  localparam int WCNT_W          = 2;

  // Stream layout: w0 = cst[31:0]; w1 = {grd[5:0], cst[57:32]}; w2 = {3'b0, grd[34:6]}
  localparam int W1_CST_BITS = FINV_CST_W - WORD_W;
  localparam int W1_GRD_BITS = WORD_W - W1_CST_BITS;
  localparam int W2_GRD_BITS = FINV_GRD_W - W1_GRD_BITS;
  localparam int W2_RSVD_BITS = WORD_W - W2_GRD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/finv_table_ram.sv
// finv_table_ram: simple dual-port table RAM, one write and one registered read port.
// A same-address read and write in one cycle returns the old entry.
`default_nettype none

module finv_table_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 58
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; table contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/finv_table_writer.sv
// finv_table_writer: loads the finv constant/gradient seed tables from a 32-bit word stream
// (three words per entry) and serves them through a 1-cycle registered read port.
`default_nettype none

module finv_table_writer
  import finv_table_pkg::*;
#(
  parameter int ADDR_W = FINV_ADDR_W,
  parameter int CST_W  = FINV_CST_W,
  parameter int GRD_W  = FINV_GRD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CST_W-1:0]  rd_cst,
  output logic [GRD_W-1:0]  rd_grd
);

  localparam int CST_HI_W = CST_W - WORD_W;
  localparam int GRD_LO_W = WORD_W - CST_HI_W;
  localparam int GRD_HI_W = GRD_W - GRD_LO_W;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] word_cnt;
  logic [ADDR_W-1:0] entry_idx;
  logic [WORD_W-1:0] stage_w0;
  logic [WORD_W-1:0] stage_w1;
  logic              err_q;
  logic              accept;
  logic              wr_en;
  logic              last_entry;
  logic [CST_W-1:0]  wr_cst;
  logic [GRD_W-1:0]  wr_grd;

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state == ST_LOAD);
  assign done    = (state == ST_DONE);
  assign err     = err_q;

  // A word coinciding with start belongs to the aborted load and is dropped.
  assign accept     = s_valid && s_ready && !start && !rst;
  assign wr_en      = accept && (word_cnt == WCNT_W'(WORDS_PER_ENTRY - 1));
  assign last_entry = &entry_idx;
  assign wr_cst     = {stage_w1[CST_HI_W-1:0], stage_w0};
  assign wr_grd     = {s_data[GRD_HI_W-1:0], stage_w1[WORD_W-1:CST_HI_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_LOAD;
    end else if (wr_en && last_entry) begin
      state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      word_cnt  <= '0;
      entry_idx <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      if (wr_en) begin
        word_cnt <= '0;
        err_q    <= err_q | (|s_data[WORD_W-1:GRD_HI_W]);
        if (!last_entry) begin
          entry_idx <= entry_idx + ADDR_W'(1);
        end
      end else begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && word_cnt == WCNT_W'(0)) begin
      stage_w0 <= s_data;
    end
    if (accept && word_cnt == WCNT_W'(1)) begin
      stage_w1 <= s_data;
    end
  end

  finv_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CST_W)
  ) u_cst_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (entry_idx),
    .wr_data (wr_cst),
    .rd_addr (rd_addr),
    .rd_data (rd_cst)
  );

  finv_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (GRD_W)
  ) u_grd_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (entry_idx),
    .wr_data (wr_grd),
    .rd_addr (rd_addr),
    .rd_data (rd_grd)
  );

endmodule

`default_nettype wire

// File: tb/tb_finv_table_writer.sv
// tb_finv_table_writer: reference model of the loader plus a read scoreboard checked every cycle.
`default_nettype none

module tb_finv_table_writer;

  localparam int AW    = 10;
  localparam int CW    = 58;
  localparam int GW    = 35;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] rd_addr = '0;
  logic [CW-1:0] rd_cst;
  logic [GW-1:0] rd_grd;

  finv_table_writer #(
    .ADDR_W (AW),
    .CST_W  (CW),
    .GRD_W  (GW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_addr (rd_addr),
    .rd_cst  (rd_cst),
    .rd_grd  (rd_grd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            known;
    logic [CW-1:0] cst;
    logic [GW-1:0] grd;
  } rd_exp_t;

  typedef enum {M_IDLE, M_LOAD, M_DONE} mstate_t;

  rd_exp_t       rd_q[$];
  logic [CW-1:0] m_cst [DEPTH];
  logic [GW-1:0] m_grd [DEPTH];
  bit            m_known [DEPTH];
  mstate_t       m_state = M_IDLE;
  int            m_wcnt = 0;
  int            m_idx = 0;
  bit            m_err = 1'b0;
  logic [31:0]   m_st0 = '0;
  logic [31:0]   m_st1 = '0;
  int            checks = 0;
  int            errors = 0;
  int            dut_hs = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: record the expected read, advance the model, then compare at the next negedge.
  task automatic step(output bit acc);
    rd_exp_t e;
    rd_exp_t p;
    if (rst) begin
      e.known = 1'b1;
      e.cst   = '0;
      e.grd   = '0;
    end else begin
      e.known = m_known[rd_addr];
      e.cst   = m_cst[rd_addr];
      e.grd   = m_grd[rd_addr];
    end
    rd_q.push_back(e);
    acc = !rst && !start && s_valid && (m_state == M_LOAD);
    if (!rst && !start && s_valid && s_ready) dut_hs++;
    if (rst) begin
      m_state = M_IDLE; m_wcnt = 0; m_idx = 0; m_err = 1'b0;
    end else if (start) begin
      m_state = M_LOAD; m_wcnt = 0; m_idx = 0; m_err = 1'b0;
    end else if (acc) begin
      if (m_wcnt == 0) begin
        m_st0 = s_data;
      end else if (m_wcnt == 1) begin
        m_st1 = s_data;
      end else begin
        m_cst[m_idx]   = {m_st1[25:0], m_st0};
        m_grd[m_idx]   = {s_data[28:0], m_st1[31:26]};
        m_known[m_idx] = 1'b1;
        if (s_data[31:29] != 3'b000) m_err = 1'b1;
        if (m_idx == DEPTH - 1) m_state = M_DONE;
        else m_idx++;
      end
      m_wcnt = (m_wcnt == 2) ? 0 : m_wcnt + 1;
    end
    @(negedge clk);
    check_eq("s_ready", 64'(s_ready), 64'(m_state == M_LOAD));
    check_eq("busy", 64'(busy), 64'(m_state == M_LOAD));
    check_eq("done", 64'(done), 64'(m_state == M_DONE));
    check_eq("err", 64'(err), 64'(m_err));
    p = rd_q.pop_front();
    if (p.known) begin
      check_eq("rd_cst", 64'(rd_cst), 64'(p.cst));
      check_eq("rd_grd", 64'(rd_grd), 64'(p.grd));
    end
  endtask

  function automatic logic [95:0] entry_words(input int i, input int v);
    logic [CW-1:0] c;
    logic [GW-1:0] g;
    case (v)
      0: begin
        c = CW'(i * 3 + 1);
        g = GW'(i) ^ GW'('h155);
      end
      1: begin
        c = 58'h1AB_CDEF_0123_4567 ^ CW'(i * 1001);
        g = 35'h4_5555_AAAA ^ GW'(i * 17);
      end
      default: begin
        c = (CW'(i) << 40) | CW'('h5A5A5);
        g = ~GW'(i);
      end
    endcase
    return {3'b000, g[34:6], g[5:0], c[57:32], c[31:0]};
  endfunction

  task automatic put_word(input logic [31:0] w, input bit rnd);
    bit acc;
    acc = 1'b0;
    s_data = w;
    for (int t = 0; t < 64 && !acc; t++) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(acc);
    end
    s_valid = 1'b0;
    if (!acc) check_eq("put_word_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_entries(input int first, input int last, input int v, input bit rnd,
                              input int bad);
    logic [95:0] w;
    for (int i = first; i <= last; i++) begin
      w = entry_words(i, v);
      if (i == bad) begin
        w[95:64] = 32'hE000_0000;
        w[63:58] = 6'd0;
      end
      put_word(w[31:0], rnd);
      put_word(w[63:32], rnd);
      put_word(w[95:64], rnd);
    end
  endtask

  // start is driven together with a valid word that must be ignored.
  task automatic pulse_start();
    bit acc;
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hBAD0_BAD0;
    step(acc);
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic readback();
    bit acc;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      step(acc);
    end
    step(acc);
  endtask

  initial begin
    bit acc;
    logic [95:0] w;

    // Reset state
    rst = 1'b1;
    step(acc);
    step(acc);
    rst = 1'b0;
    step(acc);

    // Full load, then words after done must not be taken
    pulse_start();
    load_entries(0, DEPTH - 1, 0, 1'b0, -1);
    step(acc);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    step(acc);
    step(acc);
    s_valid = 1'b0;
    readback();

    // Random valid gaps
    dut_hs = 0;
    pulse_start();
    load_entries(0, DEPTH - 1, 0, 1'b1, -1);
    check_eq("accepted_words", 64'(dut_hs), 64'(3 * DEPTH));
    readback();

    // Reserved bits set in entry 5's last word
    pulse_start();
    load_entries(0, 9, 1, 1'b0, 5);
    step(acc);
    step(acc);

    // Restart mid-entry 7, then overwrite from 0 while reading entry 3
    pulse_start();
    load_entries(0, 6, 2, 1'b0, -1);
    w = entry_words(7, 2);
    put_word(w[31:0], 1'b0);
    put_word(w[63:32], 1'b0);
    pulse_start();
    rd_addr = AW'(3);
    load_entries(0, 5, 1, 1'b0, -1);
    readback();

    // Reset in the middle of entry 100
    pulse_start();
    load_entries(0, 99, 2, 1'b1, -1);
    w = entry_words(100, 2);
    put_word(w[31:0], 1'b0);
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    step(acc);
    readback();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
